// File: rtl/tone_decoder.sv
// tone_decoder: measures the half-period of a square-wave speaker signal and
// classifies it as one of the natural notes C4..B4 (note index 1..7).
// A note is confirmed after MATCH_N consecutive matching half-periods and is
// reported as an index, as a one-hot LED pattern and with a change strobe.
//
// Build option: define TONE_DECODER_HOLD_EN to keep the last confirmed note
// on note/led through silence. note_valid still drops, and the silence event
// itself does not strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no reference edge yet; the next edge only arms measurement
// ST_ARMED | every edge closes a half-period and is classified
module tone_decoder #(
    parameter int TICK_DIV      = 100,
    parameter int MATCH_N       = 4,
    parameter int TOL_SHIFT     = 6,
    parameter int SILENCE_TICKS = 4000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       speaker_in,
    output logic [2:0] note,
    output logic [6:0] led,
    output logic       note_valid,
    output logic       note_strobe
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(SILENCE_TICKS + 1);
    localparam int SW = $clog2(MATCH_N + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    // Nominal half-periods in ticks for notes 1..7.
    function automatic int nom_of(input int k);
        case (k)
            1:       return 1911;
            2:       return 1703;
            3:       return 1517;
            4:       return 1432;
            5:       return 1276;
            6:       return 1136;
            7:       return 1012;
            default: return 0;
        endcase
    endfunction

    // Returns the note whose inclusive tolerance window holds m, or 0.
    function automatic logic [2:0] classify(input logic [CW-1:0] m);
        logic [2:0] hit;
        int         mi;
        int         nom;
        int         tol;
        hit = 3'd0;
        mi  = int'(m);
        for (int k = 1; k <= 7; k++) begin
            nom = nom_of(k);
            tol = nom >> TOL_SHIFT;
            if ((mi >= nom - tol) && (mi <= nom + tol)) begin
                hit = 3'(k);
            end
        end
        return hit;
    endfunction

    function automatic logic [6:0] led_of(input logic [2:0] n);
        logic [6:0] l;
        l = 7'd0;
        if (n != 3'd0) begin
            l = 7'(7'd1 << (n - 3'd1));
        end
        return l;
    endfunction

    logic          sync_a_q, sync_a_d;
    logic          sync_b_q, sync_b_d;
    logic          prev_q, prev_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    cand_q, cand_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [2:0]    note_q, note_d;
    logic [6:0]    led_q, led_d;
    logic          valid_q, valid_d;
    logic          strobe_q, strobe_d;

    logic          edge_w;
    logic          tick_w;
    logic          silence_w;
    logic [2:0]    match_w;

    assign edge_w    = sync_b_q ^ prev_q;
    assign tick_w    = (presc_q == PW'(TICK_DIV - 1));
    // Silence fires only on the tick that brings the counter to the limit;
    // once saturated it stays quiet. A coincident edge wins.
    assign silence_w = tick_w && (cnt_q == CW'(SILENCE_TICKS - 1)) && !edge_w;
    // The measurement is the count accumulated before this cycle; the tick
    // that coincides with the closing edge is not part of it.
    assign match_w   = classify(cnt_q);

    // Next-state logic: synchronizer, timebase, streak tracking and outputs.
    always_comb begin
        sync_a_d = speaker_in;
        sync_b_d = sync_a_q;
        prev_d   = sync_b_q;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        cand_d   = cand_q;
        streak_d = streak_q;
        note_d   = note_q;
        led_d    = led_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;

        if (edge_w || tick_w) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (edge_w) begin
            cnt_d = '0;
        end else if (tick_w && (cnt_q != CW'(SILENCE_TICKS))) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (edge_w) begin
            if (state_q == ST_IDLE) begin
                state_d = ST_ARMED;
            end else begin
                if (match_w == 3'd0) begin
                    streak_d = '0;
                end else if (match_w == cand_q) begin
                    if (streak_q != SW'(MATCH_N)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else begin
                    cand_d   = match_w;
                    streak_d = SW'(1);
                end

                // A held note (valid low) that is re-confirmed becomes valid
                // again without a strobe, since its value does not change.
                if ((match_w != 3'd0) && (streak_d == SW'(MATCH_N)) &&
                    ((cand_d != note_q) || !valid_q)) begin
                    note_d   = cand_d;
                    led_d    = led_of(cand_d);
                    valid_d  = 1'b1;
                    strobe_d = (cand_d != note_q);
                end
            end
        end else if (silence_w) begin
            state_d  = ST_IDLE;
            streak_d = '0;
            valid_d  = 1'b0;
`ifdef TONE_DECODER_HOLD_EN
            note_d   = note_q;
`else
            note_d   = 3'd0;
            led_d    = 7'd0;
            strobe_d = (note_q != 3'd0);
`endif
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a_q <= 1'b0;
            sync_b_q <= 1'b0;
            prev_q   <= 1'b0;
            presc_q  <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            cand_q   <= 3'd0;
            streak_q <= '0;
            note_q   <= 3'd0;
            led_q    <= 7'd0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync_a_q <= sync_a_d;
            sync_b_q <= sync_b_d;
            prev_q   <= prev_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            streak_q <= streak_d;
            note_q   <= note_d;
            led_q    <= led_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
        end
    end

    assign note        = note_q;
    assign led         = led_q;
    assign note_valid  = valid_q;
    assign note_strobe = strobe_q;

endmodule
